// File: rtl/adder_result_sink.sv
// Receive side of the adder datapath: buffers W-bit results in a DEPTH-entry FIFO,
// drains them downstream and keeps a per-frame checksum and beat count.
module adder_result_sink #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int CW    = 8
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       clr,
  input  logic                       in_valid,
  input  logic [W-1:0]               in_data,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [W-1:0]               out_data,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fill,
  output logic [CW-1:0]              frame_cnt,
  output logic [W-1:0]               checksum,
  output logic                       done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]     mem_data [DEPTH];
  logic [DEPTH-1:0] mem_last;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Handshakes: a beat transfers on a posedge where valid and ready are both high.
  // out_valid depends only on registered occupancy; in_ready may look at out_ready so
  // a full FIFO still accepts when its head is being drained in the same cycle.
  assign out_valid = (fill != '0);
  assign in_ready  = (fill < FULL) || (out_valid && out_ready);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
  assign out_last  = out_valid && mem_last[rd_ptr];

  // Storage needs no reset: every read is qualified by the occupancy count.
  always_ff @(posedge CLK) begin
    if (push && !clr) begin
      mem_data[wr_ptr] <= in_data;
      mem_last[wr_ptr] <= in_last;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      frame_cnt <= '0;
      checksum  <= '0;
      done      <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      frame_cnt <= '0;
      checksum  <= '0;
      done      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
      if (push) begin
        // A set done flag means the previous beat closed a frame; this one opens a new one.
        if (done) begin
          checksum  <= in_data;
          frame_cnt <= CW'(1);
        end else begin
          checksum <= checksum + in_data;
          if (frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
        end
        done <= in_last;
      end
    end
  end

endmodule
